change_dispenser: RTL

Downstream stage of the vending core: it takes the change amount the core reports alongside a dispense and pays it out as individual coins to the hopper, largest denomination first. It uses a valid/ready handshake per coin. With the inventory feature compiled in, it tracks per-denomination coin stock and reports any shortfall it cannot pay.

---
 rtl/change_dispenser.sv | 102 ++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as coins, largest first (inventory tracking under CHANGE_INVENTORY_EN)
module change_dispenser #(
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] change_in,
   input  logic       coin_ready,
   input  logic       refill,
   output logic       coin_valid,
   output logic [2:0] coin_code,
   output logic       busy,
   output logic       done,
   output logic       shortfall,
   output logic [7:0] shortfall_amt
);
   typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;
   state_t state, next;
   logic [7:0] remaining;
   logic [2:0] code, pick;
   logic       found;
   logic [4:0] avail;

   function automatic logic [7:0] coin_val(input logic [2:0] c);
      return c == 3'd0 ? 8'd20 : c == 3'd1 ? 8'd10 : c == 3'd2 ? 8'd5 : c == 3'd3 ? 8'd2 : 8'd1;
   endfunction

`ifdef CHANGE_INVENTORY_EN
   logic [STOCK_W-1:0] stock [5];
   // stock counters: reload on reset or idle refill, spend one per accepted coin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      end else if (state == IDLE && refill) begin
         for (int i = 0; i < 5; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      end else if (state == OFFER && coin_ready && stock[code] != '0) begin
         stock[code] <= stock[code] - STOCK_W'(1);
      end
   end
   // a denomination is usable only while it has coins left
   always_comb begin
      for (int i = 0; i < 5; i++) avail[i] = stock[i] != '0;
   end
   // whatever is still owed when we reach DONE is the shortfall
   assign shortfall     = state == DONE && remaining != 8'd0;
   assign shortfall_amt = state == DONE ? remaining : 8'd0;
`else
   logic unused_cfg;
   assign unused_cfg    = refill & (STOCK_INIT > 0) & (STOCK_W > 0);
   assign avail         = '1;
   assign shortfall     = 1'b0;
   assign shortfall_amt = 8'd0;
`endif

   // largest usable denomination not exceeding the remaining amount; scan small-to-large so the largest wins
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (avail[i] && coin_val(3'(i)) <= remaining) begin
            found = 1'b1;
            pick  = 3'(i);
         end
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   // next-state: a found coin implies remaining is nonzero, so no coin means finished or short
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = load ? SELECT : IDLE;
         SELECT:  next = found ? OFFER : DONE;
         OFFER:   next = coin_ready ? SELECT : OFFER;
         default: next = IDLE;
      endcase
   end

   // datapath: capture amount, latch chosen coin, deduct on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= 8'd0;
         code      <= 3'd0;
      end else begin
         if (state == IDLE && load) remaining <= change_in;
         if (state == SELECT && found) code <= pick;
         if (state == OFFER && coin_ready) remaining <= remaining - coin_val(code);
      end
   end

   assign coin_valid = state == OFFER;
   assign coin_code  = code;
   assign busy       = state != IDLE;
   assign done       = state == DONE;
endmodule
